// File: rtl/mult_arb_2.sv
// ============================================================================
//  Module   : mult_arb_2
//  Brief    : Round-robin arbiter sharing one pipelined 8x8 multiplier among
//             NREQ requesters. A tag pipeline follows each issued operation
//             so that every product is returned to the requester that issued it.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_arb_2 #(
    parameter int NREQ     = 4,
    parameter int MULT_LAT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    op_a,
    input  logic [8*NREQ-1:0]    op_b,
    input  logic                 flush,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      res_vld,
    output logic [15:0]          res_data,
    output logic                 mult_en,
    output logic [7:0]           mult_1,
    output logic [7:0]           mult_2,
    input  logic [15:0]          mult_result,
    input  logic                 mult_rdy,
    output logic                 busy,
    output logic                 err
);

    // Requester index width (at least one bit so a single requester still works)
    localparam int c_IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Outstanding count spans 0 .. MULT_LAT+1 (grant-to-retire is 1+MULT_LAT cycles)
    localparam int c_CW  = $clog2(MULT_LAT + 2);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [c_IDW-1:0]   r_rr_ptr;
    logic [c_CW-1:0]    r_cnt;
    logic               r_err;

    // Issue stage: operands and tag of the operation granted last cycle
    logic               r_mult_en;
    logic [7:0]         r_mult_1;
    logic [7:0]         r_mult_2;
    logic [c_IDW-1:0]   r_issue_id;

    // Tag pipeline aligned with the multiplier latency
    logic [MULT_LAT-1:0] r_tag_v;
    logic [c_IDW-1:0]    r_tag_id [MULT_LAT];

    logic               w_grant_ok;
    logic               w_any_gnt;
    logic [c_IDW-1:0]   w_gnt_id;
    logic [NREQ-1:0]    w_gnt;
    logic               w_tag_out_v;
    logic [c_IDW-1:0]   w_tag_out_id;

    // Modulo-NREQ addition of two requester indices
    function automatic logic [c_IDW-1:0] wrap_add(input logic [c_IDW-1:0] base,
                                                   input logic [c_IDW-1:0] step);
        logic [c_IDW:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= (c_IDW+1)'(NREQ)) begin
            sum = sum - (c_IDW+1)'(NREQ);
        end
        return sum[c_IDW-1:0];
    endfunction

    // Grants are suppressed in reset, while flushing and while draining
    assign w_grant_ok = !rst && !flush && (r_state != S_DRAIN);

    // Round-robin search: first requester at or after the pointer wins
    always_comb begin
        w_gnt     = '0;
        w_gnt_id  = '0;
        w_any_gnt = 1'b0;
        if (w_grant_ok) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!w_any_gnt && req[wrap_add(r_rr_ptr, c_IDW'(k))]) begin
                    w_any_gnt = 1'b1;
                    w_gnt_id  = wrap_add(r_rr_ptr, c_IDW'(k));
                end
            end
            if (w_any_gnt) begin
                w_gnt[w_gnt_id] = 1'b1;
            end
        end
    end

    assign gnt = w_gnt;

    // Capture granted operands, issue to the multiplier, advance the pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mult_en  <= 1'b0;
            r_mult_1   <= 8'd0;
            r_mult_2   <= 8'd0;
            r_issue_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_mult_en <= w_any_gnt;
            if (w_any_gnt) begin
                r_mult_1   <= op_a[8*int'(w_gnt_id) +: 8];
                r_mult_2   <= op_b[8*int'(w_gnt_id) +: 8];
                r_issue_id <= w_gnt_id;
                r_rr_ptr   <= wrap_add(w_gnt_id, c_IDW'(1));
            end
        end
    end

    assign mult_en = r_mult_en;
    assign mult_1  = r_mult_1;
    assign mult_2  = r_mult_2;

    // Shift the {valid,id} tag of every issue cycle toward the result port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v <= '0;
            for (int k = 0; k < MULT_LAT; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_v[0]  <= r_mult_en;
            r_tag_id[0] <= r_issue_id;
            for (int k = 1; k < MULT_LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    assign w_tag_out_v  = r_tag_v[MULT_LAT-1];
    assign w_tag_out_id = r_tag_id[MULT_LAT-1];

    // Route the multiplier result to the requester named by the output tag
    always_comb begin
        res_vld  = '0;
        res_data = 16'd0;
        if (!rst && mult_rdy && w_tag_out_v) begin
            res_vld[w_tag_out_id] = 1'b1;
            res_data              = mult_result;
        end
    end

    // Outstanding operations: grant increments, tag retire decrements
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case ({w_any_gnt, w_tag_out_v})
                2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
                2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky flag: result valid and tag valid must always coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (mult_rdy != w_tag_out_v) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DRAIN is held for as long as flush stays high
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if ((|req) && !flush) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_state_nxt = S_DRAIN;
                end else if ((r_cnt == '0) && !(|req)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if ((r_cnt == '0) && !flush) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE) || (r_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_mult_arb_2.sv
// ============================================================================
//  Module   : tb_mult_arb_2
//  Brief    : Self-checking bench for mult_arb_2 with a pipelined multiplier
//             stub, a transaction-level reference model and directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mult_arb_2;

    localparam int NREQ     = 4;
    localparam int MULT_LAT = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [8*NREQ-1:0]    op_a;
    logic [8*NREQ-1:0]    op_b;
    logic                 flush;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      res_vld;
    logic [15:0]          res_data;
    logic                 mult_en;
    logic [7:0]           mult_1;
    logic [7:0]           mult_2;
    logic [15:0]          mult_result;
    logic                 mult_rdy;
    logic                 busy;
    logic                 err;
    logic                 inj_rdy;

    always #5 clk = ~clk;

    mult_arb_2 #(.NREQ(NREQ), .MULT_LAT(MULT_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .gnt         (gnt),
        .res_vld     (res_vld),
        .res_data    (res_data),
        .mult_en     (mult_en),
        .mult_1      (mult_1),
        .mult_2      (mult_2),
        .mult_result (mult_result),
        .mult_rdy    (mult_rdy),
        .busy        (busy),
        .err         (err)
    );

    // Multiplier stub: fixed MULT_LAT latency, reset from the same rst
    logic [MULT_LAT-1:0] s_v;
    logic [15:0]         s_d [MULT_LAT];

    always @(posedge clk) begin
        if (rst) begin
            s_v <= '0;
            for (int k = 0; k < MULT_LAT; k++) s_d[k] <= 16'd0;
        end else begin
            s_v    <= {s_v[MULT_LAT-2:0], mult_en};
            s_d[0] <= 16'(mult_1) * 16'(mult_2);
            for (int k = 1; k < MULT_LAT; k++) s_d[k] <= s_d[k-1];
        end
    end

    assign mult_rdy    = s_v[MULT_LAT-1] | inj_rdy;
    assign mult_result = s_d[MULT_LAT-1];

    // Bookkeeping
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Event logs of observed grants and results for the literal checks
    typedef struct {int c; int id; int data;} ev_t;
    ev_t glog[$];
    ev_t rlog[$];

    function automatic int oh2id(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
        return -1;
    endfunction

    function automatic int g_id(input int i);
        return (i < glog.size()) ? glog[i].id : -1;
    endfunction
    function automatic int g_cyc(input int i);
        return (i < glog.size()) ? glog[i].c : -1;
    endfunction
    function automatic int r_id(input int i);
        return (i < rlog.size()) ? rlog[i].id : -1;
    endfunction
    function automatic int r_data(input int i);
        return (i < rlog.size()) ? rlog[i].data : -1;
    endfunction
    function automatic int r_cyc(input int i);
        return (i < rlog.size()) ? rlog[i].c : -1;
    endfunction

    // Reference model: pending operations with their due cycle
    typedef struct {int id; int prod; int due;} pend_t;
    pend_t m_q[$];
    int    m_ptr  = 0;
    int    m_mode = 0;     // 0 idle, 1 running, 2 draining
    int    m_en   = 0;
    int    m_m1   = 0;
    int    m_m2   = 0;
    int    m_err  = 0;

    // Compare process: predicts every output each cycle, then advances the model
    initial begin : compare
        int            gid;
        int            sz;
        bit            due;
        logic [NREQ-1:0] e_gnt;
        logic [NREQ-1:0] e_rv;
        logic [15:0]   e_rd;
        logic          e_busy;
        @(posedge clk);
        forever begin
            @(negedge clk);
            gid = -1;
            if (!rst && !flush && m_mode != 2) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (gid < 0 && req[(m_ptr + k) % NREQ]) gid = (m_ptr + k) % NREQ;
                end
            end
            e_gnt = '0;
            if (gid >= 0) e_gnt[gid] = 1'b1;
            sz  = m_q.size();
            due = (sz > 0) && (m_q[0].due == cyc);
            e_rv = '0;
            e_rd = 16'd0;
            if (!rst && due && mult_rdy) begin
                e_rv[m_q[0].id] = 1'b1;
                e_rd = 16'(m_q[0].prod);
            end
            e_busy = (m_mode != 0) || (sz != 0);

            chk("gnt",      32'(gnt),      32'(e_gnt));
            chk("res_vld",  32'(res_vld),  32'(e_rv));
            chk("res_data", 32'(res_data), 32'(e_rd));
            chk("mult_en",  32'(mult_en),  32'(m_en));
            chk("mult_1",   32'(mult_1),   32'(m_m1));
            chk("mult_2",   32'(mult_2),   32'(m_m2));
            chk("busy",     32'(busy),     32'(e_busy));
            chk("err",      32'(err),      32'(m_err));

            if (gnt != '0)     glog.push_back('{cyc, oh2id(gnt), 0});
            if (res_vld != '0) rlog.push_back('{cyc, oh2id(res_vld), int'(res_data)});

            if (rst) begin
                m_q.delete();
                m_ptr = 0; m_mode = 0; m_en = 0; m_m1 = 0; m_m2 = 0; m_err = 0;
            end else begin
                if (due != mult_rdy) m_err = 1;
                case (m_mode)
                    0: if (req != '0 && !flush) m_mode = 1;
                    1: if (flush) m_mode = 2;
                       else if (sz == 0 && req == '0) m_mode = 0;
                    default: if (sz == 0 && !flush) m_mode = 0;
                endcase
                if (due) void'(m_q.pop_front());
                m_en = (gid >= 0);
                if (gid >= 0) begin
                    m_m1  = int'(op_a[8*gid +: 8]);
                    m_m2  = int'(op_b[8*gid +: 8]);
                    m_q.push_back('{gid, m_m1 * m_m2, cyc + 1 + MULT_LAT});
                    m_ptr = (gid + 1) % NREQ;
                end
            end
            cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        glog.delete();
        rlog.delete();
    endtask

    // Directed stimulus with literal expectations
    initial begin : stim
        int c0;
        rst = 1'b1; req = '0; op_a = '0; op_b = '0; flush = 1'b0; inj_rdy = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err",  32'(err),  32'd0);
        chk("rst_men",  32'(mult_en), 32'd0);

        // Single operation on requester 2: 0x0F * 0x11
        clear_logs();
        op_a[23:16] = 8'h0F; op_b[23:16] = 8'h11; req = 4'b0100;
        c0 = cyc;
        tick(1);
        req = '0;
        tick(12);
        chk("s1_gnt_id",  32'(g_id(0)),  32'd2);
        chk("s1_gnt_cyc", 32'(g_cyc(0)), 32'(c0));
        chk("s1_res_id",  32'(r_id(0)),  32'd2);
        chk("s1_res",     32'(r_data(0)), 32'h00FF);
        chk("s1_lat",     32'(r_cyc(0) - c0), 32'd9);

        // Four requesters held for 8 cycles, operands (i+1, 3)
        pulse_rst();
        clear_logs();
        for (int i = 0; i < NREQ; i++) begin
            op_a[8*i +: 8] = 8'(i + 1);
            op_b[8*i +: 8] = 8'd3;
        end
        req = 4'hF;
        tick(8);
        req = '0;
        tick(14);
        chk("s2_ngnt", 32'(glog.size()), 32'd8);
        chk("s2_nres", 32'(rlog.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("s2_gnt_order", 32'(g_id(i)),   32'(i % 4));
            chk("s2_res_data",  32'(r_data(i)), 32'(3 * ((i % 4) + 1)));
        end
        chk("s2_res_span", 32'(r_cyc(7) - r_cyc(0)), 32'd7);

        // Operand extremes: 0x00*0xAB on req 0, 0xFF*0xFF on req 1
        pulse_rst();
        clear_logs();
        op_a[7:0] = 8'h00; op_b[7:0] = 8'hAB;
        op_a[15:8] = 8'hFF; op_b[15:8] = 8'hFF;
        req = 4'b0011;
        tick(1);
        req = 4'b0010;
        tick(1);
        req = '0;
        tick(12);
        chk("s3_zero", 32'(r_data(0)), 32'h0000);
        chk("s3_max",  32'(r_data(1)), 32'hFE01);
        chk("s3_id1",  32'(r_id(1)),   32'd1);

        // Flush after three grants with requests still pending
        pulse_rst();
        clear_logs();
        req = 4'hF;
        tick(3);
        flush = 1'b1;
        tick(15);
        chk("s4_ngnt",   32'(glog.size()), 32'd3);
        chk("s4_nres",   32'(rlog.size()), 32'd3);
        chk("s4_busy",   32'(busy), 32'd1);
        req = '0;
        tick(1);
        chk("s4_busy_hold", 32'(busy), 32'd1);
        flush = 1'b0;
        tick(2);
        chk("s4_idle", 32'(busy), 32'd0);

        // Spurious mult_rdy with nothing in flight
        pulse_rst();
        inj_rdy = 1'b1;
        tick(1);
        inj_rdy = 1'b0;
        tick(5);
        chk("s5_err",        32'(err), 32'd1);
        tick(5);
        chk("s5_err_sticky", 32'(err), 32'd1);
        pulse_rst();
        tick(1);
        chk("s5_err_clr", 32'(err), 32'd0);

        // Reset with five operations in flight
        pulse_rst();
        req = 4'hF;
        tick(5);
        req = '0;
        tick(2);
        pulse_rst();
        clear_logs();
        tick(15);
        chk("s6_nres", 32'(rlog.size()), 32'd0);
        chk("s6_busy", 32'(busy), 32'd0);
        chk("s6_err",  32'(err),  32'd0);
        req = 4'hF;
        tick(1);
        req = '0;
        tick(2);
        chk("s6_first_gnt", 32'(g_id(0)), 32'd0);
        tick(12);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
